// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store unit: opcodes, exception codes,
// FSM state encoding and small decode helpers.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] OP_LB  = 8'h20;
    localparam logic [7:0] OP_LH  = 8'h21;
    localparam logic [7:0] OP_LW  = 8'h23;
    localparam logic [7:0] OP_LBU = 8'h24;
    localparam logic [7:0] OP_LHU = 8'h25;
    localparam logic [7:0] OP_SB  = 8'h28;
    localparam logic [7:0] OP_SH  = 8'h29;
    localparam logic [7:0] OP_SW  = 8'h2B;

    localparam logic [4:0] EXC_ADEL    = 5'h04;
    localparam logic [4:0] EXC_ADES    = 5'h05;
    localparam logic [4:0] EXC_TIMEOUT = 5'h07;

    function automatic logic is_load(input logic [7:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] a);
        logic m;
        m = 1'b0;
        if ((op == OP_LH) || (op == OP_LHU) || (op == OP_SH))
            m = a[0];
        else if ((op == OP_LW) || (op == OP_SW))
            m = (a != 2'b00);
        return m;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and lane select / sign or zero extension
// for loads. Purely combinational.
module mem_lane_align
    import mem_access_unit_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic [7:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [1:0]  lane;
    logic        half;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        // Big-endian mirrors the lane index: byte 0 of the word sits in lane 3.
        lane      = BIG_ENDIAN ? ~addr_lo : addr_lo;
        half      = BIG_ENDIAN ? ~addr_lo[1] : addr_lo[1];
        rd_byte   = rdata[{lane, 3'b000} +: 8];
        rd_half   = half ? rdata[31:16] : rdata[15:0];
        sel       = 4'b0000;
        wdata     = 32'h0;
        load_data = 32'h0;
        case (op)
            OP_LB: begin
                sel       = 4'b0001 << lane;
                load_data = {{24{rd_byte[7]}}, rd_byte};
            end
            OP_LBU: begin
                sel       = 4'b0001 << lane;
                load_data = {24'h0, rd_byte};
            end
            OP_LH: begin
                sel       = half ? 4'b1100 : 4'b0011;
                load_data = {{16{rd_half[15]}}, rd_half};
            end
            OP_LHU: begin
                sel       = half ? 4'b1100 : 4'b0011;
                load_data = {16'h0, rd_half};
            end
            OP_LW: begin
                sel       = 4'b1111;
                load_data = rdata;
            end
            OP_SB: begin
                sel   = 4'b0001 << lane;
                wdata = {4{store_data[7:0]}};
            end
            OP_SH: begin
                sel   = half ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            OP_SW: begin
                sel   = 4'b1111;
                wdata = store_data;
            end
            default: begin
                sel = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Pipeline memory stage: issues one bus transaction per load/store, stalls
// upstream while waiting, and reports alignment and bus-timeout exceptions.
//
//   state | meaning
//   IDLE  | pass-through, accept a new memory op
//   WAIT  | request on the bus, waiting for ack or timeout
//   DONE  | one-cycle write-back / exception report from registers
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter bit BIG_ENDIAN  = 1'b0,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [7:0]        aluop_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    input  logic [31:0]       alu_result_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic              flush_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_sel_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_rdata_i,
    output logic              stall_o,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [31:0]       wdata_o,
    output logic              exc_valid_o,
    output logic [4:0]        exc_code_o,
    output logic [ADDR_W-1:0] badvaddr_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_t              state_q, state_d;
    logic [7:0]          op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         sdata_q;
    logic [31:0]         rdata_q;
    logic [4:0]          wd_q;
    logic                wreg_q;
    logic                kill_q;
    logic                err_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                is_mem;
    logic                misal;
    logic                accept;
    logic                in_wait;
    logic                timeout;
    logic [3:0]          lane_sel;
    logic [31:0]         lane_wdata;
    logic [31:0]         lane_load;

    // Steering works from the registered request so bus fields hold in WAIT.
    mem_lane_align #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_lane (
        .op         (op_q),
        .addr_lo    (addr_q[1:0]),
        .store_data (sdata_q),
        .rdata      (mem_rdata_i),
        .sel        (lane_sel),
        .wdata      (lane_wdata),
        .load_data  (lane_load)
    );

    assign is_mem  = valid_i && (is_load(aluop_i) || is_store(aluop_i));
    assign misal   = is_misaligned(aluop_i, addr_i[1:0]);
    assign accept  = (state_q == ST_IDLE) && is_mem && !misal && !flush_i;
    assign in_wait = (state_q == ST_WAIT);
    // Ack wins over a timeout landing in the same cycle.
    assign timeout = in_wait && !mem_ack_i && (cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_sel_o   = 4'b0000;
        mem_wdata_o = 32'h0;
        stall_o     = 1'b0;
        wd_o        = 5'h0;
        wreg_o      = 1'b0;
        wdata_o     = 32'h0;
        exc_valid_o = 1'b0;
        exc_code_o  = 5'h0;
        badvaddr_o  = '0;
        case (state_q)
            ST_IDLE: begin
                if (!is_mem) begin
                    wd_o    = wd_i;
                    wreg_o  = wreg_i;
                    wdata_o = alu_result_i;
                end else if (flush_i) begin
                    state_d = ST_IDLE;
                end else if (misal) begin
                    exc_valid_o = 1'b1;
                    exc_code_o  = is_load(aluop_i) ? EXC_ADEL : EXC_ADES;
                    badvaddr_o  = addr_i;
                end else begin
                    stall_o = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                stall_o     = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = is_store(op_q);
                mem_addr_o  = addr_q;
                mem_sel_o   = lane_sel;
                mem_wdata_o = lane_wdata;
                if (mem_ack_i || timeout)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                wd_o        = wd_q;
                wreg_o      = wreg_q && !kill_q && !err_q;
                wdata_o     = rdata_q;
                exc_valid_o = err_q && !kill_q;
                exc_code_o  = (err_q && !kill_q) ? EXC_TIMEOUT : 5'h0;
                badvaddr_o  = (err_q && !kill_q) ? addr_q : '0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (rst) begin
            mem_req_o   = 1'b0;
            mem_we_o    = 1'b0;
            mem_addr_o  = '0;
            mem_sel_o   = 4'b0000;
            mem_wdata_o = 32'h0;
            stall_o     = 1'b0;
            wd_o        = 5'h0;
            wreg_o      = 1'b0;
            wdata_o     = 32'h0;
            exc_valid_o = 1'b0;
            exc_code_o  = 5'h0;
            badvaddr_o  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= 8'h0;
            addr_q  <= '0;
            sdata_q <= 32'h0;
            rdata_q <= 32'h0;
            wd_q    <= 5'h0;
            wreg_q  <= 1'b0;
            kill_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= aluop_i;
                addr_q  <= addr_i;
                sdata_q <= wdata_i;
                wd_q    <= wd_i;
                wreg_q  <= wreg_i && is_load(aluop_i);
                kill_q  <= 1'b0;
                err_q   <= 1'b0;
                cnt_q   <= CNT_W'(TIMEOUT_CYC - 1);
            end
            if (in_wait) begin
                if (flush_i)
                    kill_q <= 1'b1;
                if (mem_ack_i)
                    rdata_q <= lane_load;
                else if (cnt_q != '0)
                    cnt_q <= cnt_q - 1'b1;
                if (timeout)
                    err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench: little- and big-endian instances driven in lockstep and
// checked against an arithmetic model of lane selection and extension.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [7:0]  aluop_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] alu_result_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic        flush_i;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    logic        mem_req   [2];
    logic        mem_we    [2];
    logic [31:0] mem_addr  [2];
    logic [3:0]  mem_sel   [2];
    logic [31:0] mem_wdata [2];
    logic        stall     [2];
    logic [4:0]  wd        [2];
    logic        wreg      [2];
    logic [31:0] wdata     [2];
    logic        exc_valid [2];
    logic [4:0]  exc_code  [2];
    logic [31:0] badvaddr  [2];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32), .BIG_ENDIAN(1'b0), .TIMEOUT_CYC(TO)) dut_le (
        .clk(clk), .rst(rst), .valid_i(valid_i), .aluop_i(aluop_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .alu_result_i(alu_result_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .flush_i(flush_i), .mem_req_o(mem_req[0]), .mem_we_o(mem_we[0]),
        .mem_addr_o(mem_addr[0]), .mem_sel_o(mem_sel[0]), .mem_wdata_o(mem_wdata[0]),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .stall_o(stall[0]),
        .wd_o(wd[0]), .wreg_o(wreg[0]), .wdata_o(wdata[0]), .exc_valid_o(exc_valid[0]),
        .exc_code_o(exc_code[0]), .badvaddr_o(badvaddr[0])
    );

    mem_access_unit #(.ADDR_W(32), .BIG_ENDIAN(1'b1), .TIMEOUT_CYC(TO)) dut_be (
        .clk(clk), .rst(rst), .valid_i(valid_i), .aluop_i(aluop_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .alu_result_i(alu_result_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .flush_i(flush_i), .mem_req_o(mem_req[1]), .mem_we_o(mem_we[1]),
        .mem_addr_o(mem_addr[1]), .mem_sel_o(mem_sel[1]), .mem_wdata_o(mem_wdata[1]),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .stall_o(stall[1]),
        .wd_o(wd[1]), .wreg_o(wreg[1]), .wdata_o(wdata[1]), .exc_valid_o(exc_valid[1]),
        .exc_code_o(exc_code[1]), .badvaddr_o(badvaddr[1])
    );

    task automatic chk(input string tag, input int d, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0s]: got %08h expected %08h at %0t", tag, d == 0 ? "le" : "be", got, exp, $time);
        end
    endtask

    function automatic bit m_is_load(input logic [7:0] op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    endfunction

    function automatic bit m_is_store(input logic [7:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic int m_size(input logic [7:0] op);
        if (op inside {OP_LB, OP_LBU, OP_SB}) return 1;
        if (op inside {OP_LH, OP_LHU, OP_SH}) return 2;
        return 4;
    endfunction

    // Byte position within the word as seen on the bus lanes.
    function automatic int m_lane(input logic [31:0] a, input int be);
        int off;
        off = int'(a % 4);
        return (be != 0) ? 3 - off : off;
    endfunction

    function automatic logic [31:0] m_sel(input logic [7:0] op, input logic [31:0] a, input int be);
        int l;
        l = m_lane(a, be);
        if (m_size(op) == 1) return 32'(1 << l);
        if (m_size(op) == 2) return 32'(3 << (2 * (l / 2)));
        return 32'hF;
    endfunction

    function automatic logic [31:0] m_store(input logic [7:0] op, input logic [31:0] d);
        if (m_size(op) == 1) return (d % 256) * 32'h0101_0101;
        if (m_size(op) == 2) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] a, input int be,
                                           input logic [31:0] rd);
        int l;
        logic [31:0] v;
        l = m_lane(a, be);
        if (m_size(op) == 1) begin
            v = (rd >> (8 * l)) % 256;
            if (op == OP_LB && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (m_size(op) == 2) begin
            v = (rd >> (16 * (l / 2))) % 65536;
            if (op == OP_LH && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic bit m_misal(input logic [7:0] op, input logic [31:0] a);
        if (m_size(op) == 2) return (a % 2) != 0;
        if (m_size(op) == 4) return (a % 4) != 0;
        return 1'b0;
    endfunction

    // k: WAIT cycle carrying ack (0 = never); fl_wait / rst_wait: WAIT cycle for
    // flush / reset (0 = none); rd: read data presented with the ack.
    task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] sd,
                          input int k, input bit fl_idle, input int fl_wait, input int rst_wait,
                          input logic [31:0] rd);
        logic [31:0] alu;
        logic [4:0]  wdst;
        bit          wr, ld, st, mem, mis, kill, to, acked;
        alu   = $urandom;
        wdst  = 5'($urandom);
        wr    = 1'b1;
        ld    = m_is_load(op);
        st    = m_is_store(op);
        mem   = ld || st;
        mis   = mem && m_misal(op, addr);
        kill  = 1'b0;
        to    = 1'b0;
        acked = 1'b0;

        @(negedge clk);
        valid_i = 1'b1; aluop_i = op; addr_i = addr; wdata_i = sd; alu_result_i = alu;
        wd_i = wdst; wreg_i = wr; flush_i = fl_idle; mem_ack_i = 1'($urandom); mem_rdata_i = $urandom;
        #1;
        for (int d = 0; d < 2; d++) begin
            if (!mem) begin
                chk("pass_wreg", d, 32'(wreg[d]), 32'(wr));
                chk("pass_wd", d, 32'(wd[d]), 32'(wdst));
                chk("pass_wdata", d, wdata[d], alu);
                chk("pass_stall", d, 32'(stall[d]), 0);
                chk("pass_exc", d, 32'(exc_valid[d]), 0);
            end else if (fl_idle) begin
                chk("flush_stall", d, 32'(stall[d]), 0);
                chk("flush_exc", d, 32'(exc_valid[d]), 0);
                chk("flush_wreg", d, 32'(wreg[d]), 0);
            end else if (mis) begin
                chk("mis_exc", d, 32'(exc_valid[d]), 1);
                chk("mis_code", d, 32'(exc_code[d]), ld ? 32'h04 : 32'h05);
                chk("mis_badv", d, badvaddr[d], addr);
                chk("mis_wreg", d, 32'(wreg[d]), 0);
                chk("mis_stall", d, 32'(stall[d]), 0);
            end else begin
                chk("acc_stall", d, 32'(stall[d]), 1);
                chk("acc_exc", d, 32'(exc_valid[d]), 0);
            end
            chk("idle_req", d, 32'(mem_req[d]), 0);
        end
        if (!mem || fl_idle || mis) return;

        for (int i = 1; i <= TO; i++) begin
            @(negedge clk);
            valid_i = 1'($urandom); aluop_i = 8'($urandom); addr_i = $urandom; wdata_i = $urandom;
            flush_i = (i == fl_wait); mem_ack_i = (i == k);
            mem_rdata_i = (i == k) ? rd : $urandom;
            if (i == rst_wait) begin
                rst = 1'b1;
                #1;
                for (int d = 0; d < 2; d++) begin
                    chk("rst_req", d, 32'(mem_req[d]), 0);
                    chk("rst_stall", d, 32'(stall[d]), 0);
                    chk("rst_sel", d, 32'(mem_sel[d]), 0);
                end
                @(negedge clk);
                rst = 1'b0; valid_i = 1'b0; mem_ack_i = 1'b0; flush_i = 1'b0;
                #1;
                for (int d = 0; d < 2; d++) begin
                    chk("post_rst_req", d, 32'(mem_req[d]), 0);
                    chk("post_rst_stall", d, 32'(stall[d]), 0);
                end
                return;
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                chk("wait_req", d, 32'(mem_req[d]), 1);
                chk("wait_we", d, 32'(mem_we[d]), 32'(st));
                chk("wait_addr", d, mem_addr[d], addr);
                chk("wait_sel", d, 32'(mem_sel[d]), m_sel(op, addr, d));
                chk("wait_stall", d, 32'(stall[d]), 1);
                if (st) chk("wait_wdata", d, mem_wdata[d], m_store(op, sd));
            end
            if (i == fl_wait) kill = 1'b1;
            if (i == k) begin
                acked = 1'b1;
                break;
            end
        end
        to = !acked;

        @(negedge clk);
        valid_i = 1'b0; flush_i = 1'b0; mem_ack_i = 1'($urandom); mem_rdata_i = $urandom;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("done_req", d, 32'(mem_req[d]), 0);
            chk("done_stall", d, 32'(stall[d]), 0);
            chk("done_wreg", d, 32'(wreg[d]), 32'(ld && wr && !kill && !to));
            chk("done_wd", d, 32'(wd[d]), 32'(wdst));
            if (ld && wr && !kill && !to) chk("done_wdata", d, wdata[d], m_load(op, addr, d, rd));
            chk("done_exc", d, 32'(exc_valid[d]), 32'(to && !kill));
            if (to && !kill) begin
                chk("done_code", d, 32'(exc_code[d]), 32'h07);
                chk("done_badv", d, badvaddr[d], addr);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ops [9];
        logic [7:0] op;
        logic [31:0] a;
        int k, fw, rw;
        bit fi;
        ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW, 8'h01};

        rst = 1'b1; valid_i = 1'b1; aluop_i = 8'h01; addr_i = 32'h0; wdata_i = 32'h0;
        alu_result_i = 32'hDEAD_BEEF; wd_i = 5'd3; wreg_i = 1'b1; flush_i = 1'b0;
        mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
        #12;
        for (int d = 0; d < 2; d++) begin
            chk("reset_wreg", d, 32'(wreg[d]), 0);
            chk("reset_wdata", d, wdata[d], 0);
            chk("reset_req", d, 32'(mem_req[d]), 0);
            chk("reset_stall", d, 32'(stall[d]), 0);
        end
        @(negedge clk);
        rst = 1'b0;

        run_op(OP_LB,  32'h1000_0001, 32'h0,         2, 0, 0, 0, 32'h0000_8000);
        run_op(OP_SH,  32'h2000_0002, 32'h0000_1234, 1, 0, 0, 0, 32'h0);
        run_op(OP_LW,  32'h3000_0006, 32'h0,         1, 0, 0, 0, 32'h0);
        run_op(OP_SW,  32'h3000_0003, 32'h0,         1, 0, 0, 0, 32'h0);
        run_op(OP_LH,  32'h3000_0001, 32'h0,         1, 0, 0, 0, 32'h0);
        run_op(OP_LW,  32'h4000_0000, 32'h0,         0, 0, 0, 0, 32'h0);
        run_op(OP_LW,  32'h4000_0004, 32'h0,         TO, 0, 0, 0, 32'hCAFE_F00D);
        run_op(OP_LHU, 32'h5000_0002, 32'h0,         2, 0, 1, 0, 32'h8765_4321);
        run_op(OP_LB,  32'h6000_0000, 32'h0,         0, 0, 0, 2, 32'h0);
        run_op(OP_LW,  32'h6000_0008, 32'h0,         1, 0, 0, 0, 32'h1357_9BDF);
        run_op(OP_SB,  32'h7000_0003, 32'h0000_00A5, 1, 1, 0, 0, 32'h0);
        run_op(8'h01,  32'h0,         32'h0,         1, 0, 0, 0, 32'h0);

        for (int n = 0; n < 200; n++) begin
            op = ops[$urandom_range(0, 8)];
            a  = $urandom;
            k  = $urandom_range(0, TO + 1);
            fi = ($urandom_range(0, 7) == 0);
            fw = ($urandom_range(0, 5) == 0) ? $urandom_range(1, TO) : 0;
            rw = ($urandom_range(0, 19) == 0) ? $urandom_range(1, TO) : 0;
            run_op(op, a, $urandom, k, fi, fw, rw, $urandom);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
